wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  DLX writeback stage; sits between the MEM/WB boundary and the register-file write port.
//  Captures one retiring instruction per handshake and, for loads, waits for the data-memory acknowledge.
//  Aligns and extends load data, then drives the register-file write port (rf_sel/rf_we/rf_din) for one cycle.
//  Writes to r0 are suppressed.
// PARAMETERS
//  DW      32  datapath width; only 32 is supported
//  AW      5   register index width
// PORTS
//  clk           in   1   rising-edge clock
//  rst_n         in   1   asynchronous active-low reset
//  mem_valid     in   1   upstream offers an instruction
//  wb_ready      out  1   stage can accept (IDLE, or writing this cycle)
//  in_rd         in   AW  destination register index
//  in_we         in   1   instruction writes a register
//  in_load       in   1   result comes from data memory
//  in_size       in   2   00 byte, 01 half, 10/11 word
//  in_uns        in   1   zero-extend (1) / sign-extend (0) load
//  in_alo        in   2   address bits [1:0] of load
//  in_result     in   DW  ALU/link result for non-loads
//  dmem_rdata    in   DW  data-memory read word
//  dmem_ack      in   1   read data valid, one-cycle pulse
//  rf_sel        out  AW  register-file write index
//  rf_we         out  1   register-file write enable
//  rf_din        out  DW  register-file write data
//  wb_stall      out  1   load outstanding; upstream must hold
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE; all captured fields cleared.
//    - Outputs: rf_we=0, rf_sel=0, rf_din=0, wb_stall=0, wb_ready=1.
//  - Accept: on a rising clk edge, capture all in_* fields when mem_valid && wb_ready.
//  - FSM states: IDLE, WRITE, WAIT.
//    - IDLE: accept with in_load=0 -> WRITE; accept with in_load=1 -> WAIT; no accept -> IDLE.
//    - WRITE: rf_we=cap_we && cap_rd!=0; rf_din=cap_result; wb_ready=1.
//      - Back-to-back accept: in_load=0 -> WRITE, in_load=1 -> WAIT, no accept -> IDLE.
//    - WAIT: wb_stall=1, wb_ready=0, rf_we=0.
//      - dmem_ack=1 -> this same cycle: rf_we=cap_we && cap_rd!=0, rf_din=aligned data.
//      - Next state after ack: IDLE. There is no back-to-back accept from WAIT.
//  - Latency:
//    - Non-load: rf_we is asserted in the cycle after accept.
//    - Load: rf_we is asserted in the cycle dmem_ack is seen; earliest is 1 cycle after accept.
//  - rf_sel=cap_rd whenever state != IDLE; rf_sel is 0 in IDLE.
//  - Combinational outputs: rf_we, rf_sel, rf_din, wb_ready and wb_stall decode from the state and captured fields.
//  - Load alignment is big-endian; byte lane 0 = dmem_rdata[31:24].
//    - Byte: lane = cap_alo; the selected byte is extended to 32 bits per cap_uns.
//    - Half: cap_alo[1]=0 selects [31:16], 1 selects [15:0]; cap_alo[0] is ignored; extended per cap_uns.
//    - Word (10 or 11): dmem_rdata passes through unchanged.
//  - Boundary conditions:
//    - dmem_ack outside WAIT is ignored.
//    - An ack in the accept cycle is ignored.
//    - A WAIT with no ack holds indefinitely.
//    - in_rd=0 or in_we=0: the instruction still occupies the stage (WAIT is still entered for a load); rf_we stays 0.
//    - Reset mid-WAIT: the pending load is discarded with no write.
// CONFIGURATION
//  - WB_BYPASS_EN defined: adds three outputs for decode-stage forwarding:
//    - byp_valid  out  1   equal to rf_we
//    - byp_rd     out  AW  equal to rf_sel
//    - byp_data   out  DW  equal to rf_din
//  - WB_BYPASS_EN undefined: these ports do not exist; behaviour is otherwise identical.
// TESTING
//  - Reset: rst_n=0 mid-WAIT -> rf_we=0, wb_stall=0, wb_ready=1 immediately; no write after release.
//  - ALU write: accept rd=5, result=32'h1234_5678 -> next cycle rf_we=1, rf_sel=5, rf_din=32'h1234_5678.
//  - Back-to-back: 3 consecutive ALU instructions -> 3 consecutive rf_we pulses, wb_ready held 1.
//  - Signed byte load: rd=7, size=00, alo=2, uns=0, ack after 3 cycles with rdata=32'h11228033
//    -> wb_stall=1 for 3 cycles, then rf_din=32'hFFFFFF80.
//  - Half loads: rdata=32'hABCD9F00
//    - alo=2, uns=1 -> rf_din=32'h00009F00.
//    - alo=0, uns=0 -> rf_din=32'hFFFFABCD.
//  - r0 / we=0: rd=0, result=32'hDEAD_BEEF -> rf_we=0, and the next instruction is accepted the next cycle.

Source files
------------

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM/WB handshake, data-memory read return and register-file
// write port of the DLX writeback stage, bundled as one interface.
// master = upstream/memory side, slave = the writeback stage itself.
interface wb_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          mem_valid;
    logic          wb_ready;
    logic [AW-1:0] in_rd;
    logic          in_we;
    logic          in_load;
    logic [1:0]    in_size;
    logic          in_uns;
    logic [1:0]    in_alo;
    logic [DW-1:0] in_result;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;
    logic [AW-1:0] rf_sel;
    logic          rf_we;
    logic [DW-1:0] rf_din;
    logic          wb_stall;

    modport master (
        output mem_valid, in_rd, in_we, in_load, in_size, in_uns, in_alo,
               in_result, dmem_rdata, dmem_ack,
        input  wb_ready, rf_sel, rf_we, rf_din, wb_stall
    );

    modport slave (
        input  mem_valid, in_rd, in_we, in_load, in_size, in_uns, in_alo,
               in_result, dmem_rdata, dmem_ack,
        output wb_ready, rf_sel, rf_we, rf_din, wb_stall
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: DLX writeback stage. Captures one retiring instruction per
// handshake, waits for the data-memory acknowledge on loads, aligns and
// extends big-endian load data and drives the register-file write port for
// one cycle. Writes to r0 are suppressed.
// Optional feature: define WB_BYPASS_EN to add byp_valid/byp_rd/byp_data
// forwarding outputs (mirrors of rf_we/rf_sel/rf_din).
module wb_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_stage_if.slave     bus
`ifdef WB_BYPASS_EN
    ,
    output logic          byp_valid,
    output logic [AW-1:0] byp_rd,
    output logic [DW-1:0] byp_data
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [AW-1:0] cap_rd;
    logic          cap_we;
    logic [1:0]    cap_size;
    logic          cap_uns;
    logic [1:0]    cap_alo;
    logic [DW-1:0] cap_result;

    logic          ready;
    logic          accept;
    logic          wr_ok;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;
    logic [DW-1:0] aligned;

    logic          rf_we_c;
    logic [AW-1:0] rf_sel_c;
    logic [DW-1:0] rf_din_c;
    logic          stall_c;

    assign ready  = (state != WAIT);
    assign accept = bus.mem_valid && ready;
    assign wr_ok  = cap_we && (cap_rd != '0);

    // State register; reset discards any pending load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the retiring instruction on every accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_rd     <= '0;
            cap_we     <= 1'b0;
            cap_size   <= '0;
            cap_uns    <= 1'b0;
            cap_alo    <= '0;
            cap_result <= '0;
        end else if (accept) begin
            cap_rd     <= bus.in_rd;
            cap_we     <= bus.in_we;
            cap_size   <= bus.in_size;
            cap_uns    <= bus.in_uns;
            cap_alo    <= bus.in_alo;
            cap_result <= bus.in_result;
        end
    end

    // Big-endian lane select and sign/zero extension of the load word.
    always_comb begin
        byte_val = '0;
        half_val = '0;
        aligned  = bus.dmem_rdata;
        case (cap_alo)
            2'd0:    byte_val = bus.dmem_rdata[31:24];
            2'd1:    byte_val = bus.dmem_rdata[23:16];
            2'd2:    byte_val = bus.dmem_rdata[15:8];
            default: byte_val = bus.dmem_rdata[7:0];
        endcase
        half_val = cap_alo[1] ? bus.dmem_rdata[15:0] : bus.dmem_rdata[31:16];
        case (cap_size)
            2'b00:   aligned = {{(DW-8){~cap_uns & byte_val[7]}}, byte_val};
            2'b01:   aligned = {{(DW-16){~cap_uns & half_val[15]}}, half_val};
            default: aligned = bus.dmem_rdata;
        endcase
    end

    // Next-state and write-port decode from state and captured fields.
    always_comb begin
        state_nxt = state;
        rf_we_c   = 1'b0;
        rf_sel_c  = '0;
        rf_din_c  = '0;
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = bus.in_load ? WAIT : WRITE;
            end
            WRITE: begin
                rf_sel_c  = cap_rd;
                rf_we_c   = wr_ok;
                rf_din_c  = cap_result;
                state_nxt = accept ? (bus.in_load ? WAIT : WRITE) : IDLE;
            end
            WAIT: begin
                rf_sel_c = cap_rd;
                stall_c  = 1'b1;
                if (bus.dmem_ack) begin
                    rf_we_c   = wr_ok;
                    rf_din_c  = aligned;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.wb_ready = ready;
    assign bus.wb_stall = stall_c;
    assign bus.rf_we    = rf_we_c;
    assign bus.rf_sel   = rf_sel_c;
    assign bus.rf_din   = rf_din_c;

`ifdef WB_BYPASS_EN
    assign byp_valid = rf_we_c;
    assign byp_rd    = rf_sel_c;
    assign byp_data  = rf_din_c;
`endif

endmodule
